// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write sequencer for a bank of level-sensitive D latches.
// For each write it drives the data bus stable, pulses one enable, then holds.
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   req          per-requester write request, held high until ack
//   req_addr     requester i address at [i*AW +: AW]
//   req_data     requester i data at [i*W +: W]
//   ack          one-cycle completion pulse to the granted requester
//   busy         high whenever the sequencer is not idle
//   gnt_id       index of the current or most recent granted requester
//   lat_D        shared data bus to every latch D input
//   lat_En       one-hot-or-zero latch enables, one per latch word
module latch_bank_write_ctrl #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int EN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [IDW-1:0]    gnt_id,
    output logic [W-1:0]      lat_D,
    output logic [DEPTH-1:0]  lat_En
);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    // Counter reload; the ENABLE phase ends when it reaches zero.
    localparam logic [3:0] EN_LAST = 4'(EN_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   rr;
    logic [IDW-1:0]   rr_n;
    logic [IDW-1:0]   gnt_n;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_n;
    logic [3:0]       cnt;
    logic [3:0]       cnt_n;
    logic [W-1:0]     d_n;
    logic [DEPTH-1:0] en_n;
    logic [DEPTH-1:0] en_dec;
    logic [NREQ-1:0]  ack_n;
    logic             busy_n;
    logic             found;
    logic [IDW-1:0]   pick;

    // Round-robin pick: first set request at or above rr, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr) + k) % NREQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr) + k) % NREQ);
            end
        end
    end

    // Addresses at or beyond DEPTH decode to no enable at all.
    always_comb begin
        en_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            en_dec[i] = (int'(addr_q) == i);
        end
    end

    always_comb begin
        state_n = state;
        rr_n    = rr;
        gnt_n   = gnt_id;
        addr_n  = addr_q;
        cnt_n   = cnt;
        d_n     = lat_D;
        en_n    = '0;
        ack_n   = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = SETUP;
                    gnt_n   = pick;
                    addr_n  = req_addr[int'(pick)*AW +: AW];
                    d_n     = req_data[int'(pick)*W +: W];
                end
            end
            SETUP: begin
                state_n = ENABLE;
                cnt_n   = EN_LAST;
                en_n    = en_dec;
            end
            ENABLE: begin
                if (cnt == 4'd0) begin
                    state_n       = HOLD;
                    ack_n[gnt_id] = 1'b1;
                    if (int'(gnt_id) == NREQ - 1) begin
                        rr_n = '0;
                    end else begin
                        rr_n = gnt_id + IDW'(1);
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                    en_n  = en_dec;
                end
            end
            HOLD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr     <= '0;
            gnt_id <= '0;
            addr_q <= '0;
            cnt    <= '0;
            lat_D  <= '0;
            lat_En <= '0;
            ack    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            rr     <= rr_n;
            gnt_id <= gnt_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            lat_D  <= d_n;
            lat_En <= en_n;
            ack    <= ack_n;
            busy   <= busy_n;
        end
    end

endmodule
